matrix_3x3_generator: RTL and testbench
=======================================

MATRIX_3X3_GENERATOR -- requirements
Module: matrix_3x3_generator

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: active pixels per line, min 3.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: active lines per frame, min 3.
REQ-003 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have frame_start  input  1  single-cycle pulse marking a new frame.
REQ-006 SHALL have pix_valid  input  1  pix_data is a valid raster-order pixel this cycle.
REQ-007 SHALL have pix_data  input  8  grey pixel value.
REQ-008 SHALL have matrix_p11..matrix_p33  output  8 each  3x3 window, row 1 = oldest line, column 1 = leftmost pixel.
REQ-009 SHALL have matrix_finish  output  1  window outputs valid this cycle, one pulse per window.
REQ-010 SHALL have pix_finish  output  1  single-cycle end-of-frame pulse.

Function
REQ-011 SHALL keep col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters, advanced only when pix_valid=1; col wraps to 0 and row increments at IMG_WIDTH-1.
REQ-012 SHALL hold all state (counters, line buffers, window) unchanged while pix_valid=0; gaps of any length are legal.
REQ-013 SHALL keep two line buffers, each IMG_WIDTH deep, written on every pix_valid: line1 delays the input by one line, line2 delays line1 output by one line.
REQ-014 SHALL, on each pix_valid, shift the window left (pX1<=pX2, pX2<=pX3) and load p13<=line2 tap, p23<=line1 tap, p33<=pix_data.
REQ-015 SHALL assert matrix_finish 1 cycle after an accepted pixel with row>=2 and col>=2; the window is then centred on (row-1, col-1).
REQ-016 SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) matrix_finish pulses per frame; border pixels produce no window.
REQ-017 SHALL assert pix_finish 1 cycle after the final matrix_finish of a frame, never in the same cycle, so the downstream enable pipeline does not drop the last window.
REQ-018 SHALL, after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1), wrap both counters to 0; the next pixel is (0,0) of the next frame.
REQ-019 SHALL, on frame_start, zero both counters; if pix_valid=1 in the same cycle, that pixel is accepted as (0,0).
REQ-020 SHALL, on frame_start mid-frame, abandon the frame: no pix_finish for it and no windows until row>=2, col>=2 of the new frame.
REQ-021 SHALL register matrix_p* and matrix_finish; matrix_p* hold their last values while matrix_finish=0.
REQ-022 SHALL size counters as $clog2 of the parameters; no arithmetic widening is required on the 8-bit datapath.

Reset
REQ-023 SHALL, on rst=1, clear col, row, all matrix_p* to 0, matrix_finish=0 and pix_finish=0 at the next edge.
REQ-024 SHALL not require line-buffer contents to be reset; stale contents never reach a window with matrix_finish=1 (guaranteed by REQ-015).
REQ-025 SHALL give rst priority over frame_start and pix_valid in the same cycle; reset mid-frame behaves as REQ-020.

Structure
REQ-026 SHALL place the default IMG_WIDTH/IMG_HEIGHT and pixel width (8) in the shared image-processing package used by the sobel stage.
REQ-027 SHALL implement each line buffer as one sub-module, line_buffer (parameter DEPTH, ports clk, en, din, dout), instantiated twice, inferable as block RAM with a circular address counter.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel = row*16+col unless stated)
REQ-028 SHALL cover a continuous frame: first matrix_finish 1 cycle after pixel 0x22 with p11..p33 = 00,01,02,10,11,12,20,21,22; exactly 4 pulses; last window p33=0x33; pix_finish one cycle after it.
REQ-029 SHALL cover pix_valid toggling 1/0 each cycle: same 4 windows, same values as REQ-028, outputs held during gaps.
REQ-030 SHALL cover frame_start asserted after pixel 0x21: no pix_finish; a fresh frame yields 4 windows, the first again 00..22.
REQ-031 SHALL cover rst=1 for one cycle mid-frame: all outputs 0 next cycle; a following full frame matches REQ-028.
REQ-032 SHALL cover two back-to-back frames, second with pixel = 0xFF-(row*16+col): 8 windows, 2 pix_finish pulses, second frame's first window p11=0xFF, p33=0xDD.
REQ-033 SHALL cover frame_start and pix_valid in the same cycle: that pixel is (0,0), and a frame of 16 pixels yields exactly 4 windows.

Source files
------------

// File: rtl/matrix_3x3_generator_pkg.sv
// Shared image-processing definitions: default frame geometry, pixel type, and
// the 3x3 window type used by the window generator and the sobel stage.
package matrix_3x3_generator_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int PIX_W          = 8;

    typedef logic [PIX_W-1:0] pix_t;

    // Indexed [row][col]; row 0 is the oldest line, col 0 the leftmost pixel.
    typedef pix_t [2:0][2:0] win_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_3x3_generator_line_buffer.sv
// One-line pixel delay. The registered output holds the pixel written exactly
// DEPTH enables earlier, and it is valid before the next write.
module line_buffer
    import matrix_3x3_generator_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH
) (
    input  logic clk,
    input  logic en,
    input  pix_t din,
    output pix_t dout
);

    // The output register supplies one stage of delay, so the RAM holds DEPTH-1 entries.
    localparam int MEM_D = DEPTH - 1;
    localparam int AW    = cnt_w(MEM_D);
    localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_D - 1);

    pix_t           mem [MEM_D];
    logic [AW-1:0]  addr;

    always_ff @(posedge clk) begin
        if (en) begin
            dout      <= mem[addr];
            mem[addr] <= din;
            addr      <= (addr == ADDR_MAX) ? '0 : addr + AW'(1);
        end
    end

endmodule

// File: rtl/matrix_3x3_generator.sv
// Raster-stream 3x3 window generator. It outputs one registered window for each
// interior pixel and pulses pix_finish one cycle after the last window of a frame.
module matrix_3x3_generator
    import matrix_3x3_generator_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic [PIX_W-1:0] matrix_p11,
    output logic [PIX_W-1:0] matrix_p12,
    output logic [PIX_W-1:0] matrix_p13,
    output logic [PIX_W-1:0] matrix_p21,
    output logic [PIX_W-1:0] matrix_p22,
    output logic [PIX_W-1:0] matrix_p23,
    output logic [PIX_W-1:0] matrix_p31,
    output logic [PIX_W-1:0] matrix_p32,
    output logic [PIX_W-1:0] matrix_p33,
    output logic             matrix_finish,
    output logic             pix_finish
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col, col_cur;
    logic [RW-1:0] row, row_cur;
    pix_t          tap1, tap2;
    win_t          win, win_nxt, win_out;
    logic          lb_en, win_fire, last_pix, last_q;

    assign lb_en = pix_valid & ~rst;

    line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
        .clk  (clk),
        .en   (lb_en),
        .din  (pix_data),
        .dout (tap1)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_line2 (
        .clk  (clk),
        .en   (lb_en),
        .din  (tap1),
        .dout (tap2)
    );

    // When frame_start arrives with a pixel, that pixel is treated as (0,0).
    always_comb begin
        col_cur  = frame_start ? '0 : col;
        row_cur  = frame_start ? '0 : row;
        win_fire = pix_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
        last_pix = pix_valid && (row_cur == ROW_MAX) && (col_cur == COL_MAX);

        win_nxt = win;
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = tap2;
        win_nxt[1][2] = tap1;
        win_nxt[2][2] = pix_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            win           <= '0;
            win_out       <= '0;
            matrix_finish <= 1'b0;
            last_q        <= 1'b0;
            pix_finish    <= 1'b0;
        end else begin
            matrix_finish <= win_fire;
            // last_q is coincident with the final matrix_finish; pix_finish follows one cycle later.
            last_q        <= last_pix;
            pix_finish    <= last_q;
            if (pix_valid) begin
                win <= win_nxt;
                if (col_cur == COL_MAX) begin
                    col <= '0;
                    row <= (row_cur == ROW_MAX) ? '0 : row_cur + RW'(1);
                end else begin
                    col <= col_cur + CW'(1);
                    row <= row_cur;
                end
            end else if (frame_start) begin
                col <= '0;
                row <= '0;
            end
            if (win_fire) win_out <= win_nxt;
        end
    end

    assign matrix_p11 = win_out[0][0];
    assign matrix_p12 = win_out[0][1];
    assign matrix_p13 = win_out[0][2];
    assign matrix_p21 = win_out[1][0];
    assign matrix_p22 = win_out[1][1];
    assign matrix_p23 = win_out[1][2];
    assign matrix_p31 = win_out[2][0];
    assign matrix_p32 = win_out[2][1];
    assign matrix_p33 = win_out[2][2];

endmodule

// File: tb/tb_matrix_3x3_generator.sv
// Directed bench for matrix_3x3_generator on a 4x4 frame; pixel = row*16+col,
// or 0xFF minus that for inverted frames.
module tb_matrix_3x3_generator;

    logic       clk = 1'b0;
    logic       rst, frame_start, pix_valid;
    logic [7:0] pix_data;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic       matrix_finish, pix_finish;
    logic [71:0] win_obs;

    int tests = 0, fails = 0;
    int cyc = 0, last_mf = -10, npf = 0;
    logic [71:0] exp_out;
    logic [71:0] q_win[$];

    matrix_3x3_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .matrix_p11    (p11),
        .matrix_p12    (p12),
        .matrix_p13    (p13),
        .matrix_p21    (p21),
        .matrix_p22    (p22),
        .matrix_p23    (p23),
        .matrix_p31    (p31),
        .matrix_p32    (p32),
        .matrix_p33    (p33),
        .matrix_finish (matrix_finish),
        .pix_finish    (pix_finish)
    );

    always #5 clk = ~clk;

    assign win_obs = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (matrix_finish) begin
            q_win.push_back(win_obs);
            last_mf = cyc;
        end
        if (pix_finish) begin
            npf++;
            chk("pf_one_after_mf", 72'(cyc - last_mf), 72'd1);
        end
    end

    function automatic logic [7:0] pix(input bit inv, input int r, input int c);
        int v;
        v = r * 16 + c;
        return inv ? 8'(255 - v) : 8'(v);
    endfunction

    function automatic logic [71:0] exp_win(input bit inv, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], pix(inv, r - 1 + i, c - 1 + j)};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        q_win.delete();
        npf = 0;
    endtask

    task automatic feed(input bit inv, input int r, input int c, input bit gap, input bit fs);
        frame_start = fs;
        pix_valid   = 1'b1;
        pix_data    = pix(inv, r, c);
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        if (r >= 2 && c >= 2) exp_out = exp_win(inv, r - 1, c - 1);
        chk($sformatf("mf_r%0dc%0d", r, c), 72'(matrix_finish), 72'((r >= 2 && c >= 2) ? 1 : 0));
        chk($sformatf("win_r%0dc%0d", r, c), win_obs, exp_out);
        if (gap) begin
            tick();
            chk("gap_mf", 72'(matrix_finish), 72'd0);
            chk("gap_hold", win_obs, exp_out);
        end
    endtask

    task automatic frame(input bit inv, input bit gap, input bit fs_first);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                feed(inv, r, c, gap, fs_first && r == 0 && c == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_wins(input string tag, input bit inv0, input int nf);
        chk({tag, "_nwin"}, 72'(q_win.size()), 72'(4 * nf));
        chk({tag, "_npf"}, 72'(npf), 72'(nf));
        for (int k = 0; k < q_win.size() && k < 4 * nf; k++)
            chk($sformatf("%s_w%0d", tag, k), q_win[k],
                exp_win(((k / 4) == 0) ? inv0 : ~inv0, 1 + (k % 4) / 2, 1 + (k % 2)));
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        tick(); tick();
        rst = 1'b0;
        exp_out = '0;
        chk("reset_win", win_obs, 72'd0);
        chk("reset_mf", 72'(matrix_finish), 72'd0);
        chk("reset_pf", 72'(pix_finish), 72'd0);

        // continuous frame
        clear();
        frame(1'b0, 1'b0, 1'b0);
        idle(3);
        check_wins("A", 1'b0, 1);
        chk("A_first", q_win[0], 72'h000102101112202122);
        chk("A_last_p33", 72'(q_win[3][7:0]), 72'h33);

        // pix_valid toggling every cycle
        clear();
        frame(1'b0, 1'b1, 1'b0);
        idle(3);
        check_wins("B", 1'b0, 1);

        // frame_start after pixel 0x21 abandons the frame
        clear();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) feed(1'b0, r, c, 1'b0, 1'b0);
        feed(1'b0, 2, 0, 1'b0, 1'b0);
        feed(1'b0, 2, 1, 1'b0, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        idle(2);
        chk("C_no_pf", 72'(npf), 72'd0);
        frame(1'b0, 1'b0, 1'b0);
        idle(3);
        check_wins("C", 1'b0, 1);

        // reset mid-frame
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) feed(1'b0, r, c, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) feed(1'b0, 2, c, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_out = '0;
        chk("D_rst_win", win_obs, 72'd0);
        chk("D_rst_mf", 72'(matrix_finish), 72'd0);
        chk("D_rst_pf", 72'(pix_finish), 72'd0);
        clear();
        frame(1'b0, 1'b0, 1'b0);
        idle(3);
        check_wins("D", 1'b0, 1);

        // two back-to-back frames, second inverted
        clear();
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        idle(3);
        check_wins("E", 1'b0, 2);
        chk("E_f2_p11", 72'(q_win[4][71:64]), 72'hFF);
        chk("E_f2_p33", 72'(q_win[4][7:0]), 72'hDD);

        // frame_start coincident with the first pixel after a partial frame
        clear();
        for (int c = 0; c < 4; c++) feed(1'b0, 0, c, 1'b0, 1'b0);
        feed(1'b0, 1, 0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1);
        idle(3);
        check_wins("F", 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
